mul_share_ctrl: RTL

- Scheduler that shares one 4x4 sequential shift-add multiplier core (START/READY handshake, 8-bit product) between NREQ requesters.
- Round-robin arbitration, single-cycle START pulse, READY tracking, product capture, per-requester response pulse, watchdog timeout.
- Sits between the requester clients and the multiplier core. It is the only driver of the core's START, A and B inputs.

---
 rtl/mul_share_ctrl_if.sv | 28 ++
 rtl/mul_share_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl_if.sv
// Bundle of requester, response and multiplier-core signals around mul_share_ctrl.
// master = clients plus core side, slave = the scheduler.
interface mul_share_ctrl_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_p;
    logic              rsp_err;
    logic              mul_start;
    logic [3:0]        mul_a;
    logic [3:0]        mul_b;
    logic              mul_ready;
    logic [7:0]        mul_p;

    modport master (
        output req_valid, req_a, req_b, mul_ready, mul_p,
        input  req_ack, rsp_valid, rsp_p, rsp_err, mul_start, mul_a, mul_b
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_ready, mul_p,
        output req_ack, rsp_valid, rsp_p, rsp_err, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin scheduler sharing one START/READY 4x4 multiplier core between
// NREQ requesters, with a watchdog that answers with an error on a stuck core.
module mul_share_ctrl #(
    parameter int NREQ = 4,
    parameter int TMO  = 15
) (
    input  logic                 ck,
    input  logic                 rstn,
    mul_share_ctrl_if.slave      bus,
    output logic                 busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   gnt;
    logic [PW-1:0]   idx;
    logic            found;
    logic [CW-1:0]   cnt;
    logic            timeout;
    logic [3:0]      mul_a_q;
    logic [3:0]      mul_b_q;
    logic [7:0]      rsp_p_q;
    logic            rsp_err_q;
    logic [NREQ-1:0] ack_c;
    logic [NREQ-1:0] rsp_valid_c;
    logic            start_c;

    // First requester at or after ptr, wrapping around the requester ring
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign timeout = (cnt == CW'(TMO - 1));

    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Acks are gated by rstn so nothing is acknowledged while reset is held
    always_comb begin
        state_nxt   = state;
        ack_c       = '0;
        rsp_valid_c = '0;
        start_c     = 1'b0;
        case (state)
            IDLE: begin
                if (found && rstn) begin
                    ack_c     = NREQ'(1) << gnt;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                start_c   = 1'b1;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.mul_ready || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_c = NREQ'(1) << owner;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands, owner and pointer move only on a grant; READY beats the watchdog
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            rsp_p_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mul_a_q <= 4'(bus.req_a >> {gnt, 2'b00});
                        mul_b_q <= 4'(bus.req_b >> {gnt, 2'b00});
                        owner   <= gnt;
                        ptr     <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
                    end
                end
                SETTLE: begin
                    cnt <= '0;
                end
                WAIT: begin
                    if (bus.mul_ready) begin
                        rsp_p_q   <= bus.mul_p;
                        rsp_err_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (timeout) begin
                            rsp_p_q   <= '0;
                            rsp_err_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    rsp_err_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ack   = ack_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_p     = rsp_p_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mul_start = start_c;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign busy          = (state != IDLE);

endmodule
